// File: rtl/mha_pkg.sv
// Shared definitions for the multi-head-attention residual stage: FSM state
// encoding, default geometry, and the clamp helper used by the saturating
// build (MHA_RESIDUAL_SAT_EN).
package mha_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } residual_state_t;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_D_MODEL = 192;
  localparam int DEF_N_ROWS  = 197;

  // Clamp a signed value into the range of a width-bit two's complement word.
  function automatic int sat_signed(input int value, input int width);
    int max_v;
    int min_v;
    max_v = (1 << (width - 1)) - 1;
    min_v = -(1 << (width - 1));
    if (value > max_v)      return max_v;
    else if (value < min_v) return min_v;
    else                    return value;
  endfunction

endpackage

// File: rtl/mha_skip_fifo.sv
// Single-clock skip FIFO with full/empty flags. The head word is driven
// straight from the storage flops, so a word written in cycle t is visible
// at the head from cycle t+1 (no empty-to-head bypass).
module mha_skip_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              push_ok;
  logic              pop_ok;

  // A push into a full FIFO is refused even when a pop happens alongside it.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign full    = (count == (ADDR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset flushes the FIFO.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; flushing the pointers/count makes stale words unreachable.
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mha_residual_add.sv
// Residual add stage after multi-head self-attention: buffers the block
// input x in a skip FIFO and emits z = x + y for each attention output y.
// Build option: define MHA_RESIDUAL_SAT_EN to saturate the sum; otherwise
// the sum wraps to DATA_W bits.
module mha_residual_add
  import mha_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int D_MODEL    = DEF_D_MODEL,
  parameter int N_ROWS     = DEF_N_ROWS,
  parameter int SKIP_DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  output logic              ready,
  input  logic [DATA_W-1:0] x_data,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic [DATA_W-1:0] y_data,
  input  logic              y_valid,
  output logic              y_ready,
  output logic [DATA_W-1:0] z_data,
  output logic              z_valid,
  input  logic              z_ready,
  output logic              z_row_last,
  output logic              z_block_last
);

  localparam int TOTAL = N_ROWS * D_MODEL;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int COL_W = (D_MODEL > 1) ? $clog2(D_MODEL) : 1;
  localparam logic [CNT_W-1:0] TOTAL_C  = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(TOTAL - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(D_MODEL - 1);

  residual_state_t          state;
  logic [CNT_W-1:0]         in_cnt;
  logic [CNT_W-1:0]         out_cnt;
  logic [COL_W-1:0]         col;
  logic [DATA_W-1:0]        head;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     x_fire;
  logic                     y_fire;
  logic                     z_fire;
  logic signed [DATA_W:0]   sum;
  logic [DATA_W-1:0]        z_next;

  assign ready   = (state == IDLE);
  assign x_ready = (state == RUN) && !fifo_full && (in_cnt < TOTAL_C);
  // Backpressure from z_ready drops y_ready in the same cycle.
  assign y_ready = (state == RUN) && !fifo_empty && (!z_valid || z_ready);
  assign x_fire  = x_valid && x_ready;
  assign y_fire  = y_valid && y_ready;
  assign z_fire  = z_valid && z_ready;

  assign sum = $signed({head[DATA_W-1], head}) + $signed({y_data[DATA_W-1], y_data});

  // Reduce the DATA_W+1 bit sum back to DATA_W bits.
  always_comb begin
    // NOTE: always_comb outputs get a default first so no path leaves them unassigned (no latch).
    z_next = '0;
`ifdef MHA_RESIDUAL_SAT_EN
    z_next = DATA_W'(sat_signed(int'(sum), DATA_W));
`else
    z_next = DATA_W'(sum);
`endif
  end

  mha_skip_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (SKIP_DEPTH)
  ) u_skip_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (x_fire),
    .push_data (x_data),
    .pop       (y_fire),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Block FSM, beat counters and the registered z output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      in_cnt       <= '0;
      out_cnt      <= '0;
      col          <= '0;
      z_valid      <= 1'b0;
      z_data       <= '0;
      z_row_last   <= 1'b0;
      z_block_last <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (init) begin
            state   <= RUN;
            in_cnt  <= '0;
            out_cnt <= '0;
            col     <= '0;
          end
        end
        RUN:     if (z_fire && z_block_last) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // Handshakes only occur in RUN, so these never collide with the IDLE clear.
      if (x_fire) in_cnt <= in_cnt + 1'b1;

      if (y_fire) begin
        out_cnt      <= out_cnt + 1'b1;
        col          <= (col == COL_LAST) ? '0 : col + 1'b1;
        z_valid      <= 1'b1;
        z_data       <= z_next;
        z_row_last   <= (col == COL_LAST);
        z_block_last <= (out_cnt == LAST_C);
      end else if (z_fire) begin
        z_valid      <= 1'b0;
        z_row_last   <= 1'b0;
        z_block_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mha_residual_add.sv
// Directed bench for mha_residual_add with D_MODEL=4, N_ROWS=2, SKIP_DEPTH=4.
// Expected sums depend on MHA_RESIDUAL_SAT_EN, matching the DUT build.
module tb_mha_residual_add;

  typedef logic signed [7:0] vec_t [8];

  logic              clk = 1'b0;
  logic              reset;
  logic              init;
  logic              ready;
  logic signed [7:0] x_data;
  logic              x_valid;
  logic              x_ready;
  logic signed [7:0] y_data;
  logic              y_valid;
  logic              y_ready;
  logic signed [7:0] z_data;
  logic              z_valid;
  logic              z_ready;
  logic              z_row_last;
  logic              z_block_last;

  int n_assert = 0;
  int n_fail   = 0;

  vec_t x_seq = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6, 8'sd7, 8'sd8};
  vec_t y_ten = '{8'sd10, 8'sd10, 8'sd10, 8'sd10, 8'sd10, 8'sd10, 8'sd10, 8'sd10};
  vec_t z_seq = '{8'sd11, 8'sd12, 8'sd13, 8'sd14, 8'sd15, 8'sd16, 8'sd17, 8'sd18};
  vec_t x_big = '{8'sd100, -8'sd100, 8'sd100, -8'sd100, 8'sd50, -8'sd50, 8'sd127, -8'sd128};
  vec_t y_big = '{8'sd100, -8'sd100, 8'sd27, -8'sd28, 8'sd77, -8'sd79, 8'sd1, -8'sd1};
`ifdef MHA_RESIDUAL_SAT_EN
  vec_t z_big = '{8'sd127, -8'sd128, 8'sd127, -8'sd128, 8'sd127, -8'sd128, 8'sd127, -8'sd128};
`else
  vec_t z_big = '{-8'sd56, 8'sd56, 8'sd127, -8'sd128, 8'sd127, 8'sd127, -8'sd128, 8'sd127};
`endif

  mha_residual_add #(
    .DATA_W     (8),
    .D_MODEL    (4),
    .N_ROWS     (2),
    .SKIP_DEPTH (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .ready        (ready),
    .x_data       (x_data),
    .x_valid      (x_valid),
    .x_ready      (x_ready),
    .y_data       (y_data),
    .y_valid      (y_valid),
    .y_ready      (y_ready),
    .z_data       (z_data),
    .z_valid      (z_valid),
    .z_ready      (z_ready),
    .z_row_last   (z_row_last),
    .z_block_last (z_block_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_block(input string tag);
    check({tag, "_ready_idle"}, ready, 1);
    init = 1'b1;
    tick();
    init = 1'b0;
    check({tag, "_ready_run"}, ready, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, ready, 1);
    check({tag, "_x_ready"}, x_ready, 0);
    check({tag, "_y_ready"}, y_ready, 0);
    check({tag, "_z_valid"}, z_valid, 0);
    check({tag, "_z_data"}, z_data, 0);
    check({tag, "_z_row_last"}, z_row_last, 0);
    check({tag, "_z_block_last"}, z_block_last, 0);
  endtask

  // Stream one block; y can be withheld, z stalled, init pulsed, or the
  // run cut short after a given number of z beats.
  task automatic run_block(input string tag, input vec_t xs, input vec_t ys,
                           input vec_t zs, input int y_hold, input int stall_at,
                           input int init_at, input int abort_after);
    int   xi = 0;
    int   yi = 0;
    int   zi = 0;
    int   cyc = 0;
    int   stall_cnt = 0;
    logic xf, yf, zf, stalling;
    while (zi < abort_after && cyc < 200) begin
      x_valid  = (xi < 8);
      x_data   = xs[(xi < 8) ? xi : 0];
      y_valid  = (yi < 8) && (cyc >= y_hold);
      y_data   = ys[(yi < 8) ? yi : 0];
      stalling = (zi == stall_at) && (stall_cnt < 5) && z_valid;
      z_ready  = !stalling;
      init     = (cyc == init_at);
      @(negedge clk);
      if (stalling) begin
        check({tag, "_stall_z_data"}, z_data, zs[zi]);
        check({tag, "_stall_y_ready"}, y_ready, 0);
        stall_cnt++;
      end
      if (y_hold > 0 && cyc == y_hold) begin
        check({tag, "_pushes_until_full"}, xi, 4);
        check({tag, "_x_ready_full"}, x_ready, 0);
      end
      xf = x_valid && x_ready;
      yf = y_valid && y_ready;
      zf = z_valid && z_ready;
      if (zf) begin
        check($sformatf("%s_z%0d_data", tag, zi), z_data, zs[zi]);
        check($sformatf("%s_z%0d_row_last", tag, zi), z_row_last, (zi % 4) == 3);
        check($sformatf("%s_z%0d_block_last", tag, zi), z_block_last, zi == 7);
      end
      tick();
      if (xf) xi++;
      if (yf) begin
        yi++;
        if (y_hold > 0 && yi == 1) check({tag, "_x_ready_rerise"}, x_ready, 1);
      end
      if (zf) zi++;
      cyc++;
    end
    init    = 1'b0;
    x_valid = 1'b0;
    y_valid = 1'b0;
    z_ready = 1'b1;
    check({tag, "_z_beats_within_budget"}, zi, abort_after);
  endtask

  // Called right after the edge that accepted the final z beat.
  task automatic check_done(input string tag);
    check({tag, "_done_ready"}, ready, 0);
    check({tag, "_done_z_valid"}, z_valid, 0);
    tick();
    check({tag, "_idle_ready"}, ready, 1);
  endtask

  initial begin
    reset   = 1'b1;
    init    = 1'b0;
    x_valid = 1'b0;
    x_data  = '0;
    y_valid = 1'b0;
    y_data  = '0;
    z_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_reset_outputs("rst");

    // Basic block: z = 11..18, row/block markers.
    start_block("basic");
    run_block("basic", x_seq, y_ten, z_seq, 0, 99, -1, 8);
    check_done("basic");

    // Overflow boundaries: wrap or saturate depending on build.
    start_block("sat");
    run_block("sat", x_big, y_big, z_big, 0, 99, -1, 8);
    check_done("sat");

    // FIFO fills to depth 4 with y withheld.
    start_block("depth");
    run_block("depth", x_seq, y_ten, z_seq, 8, 99, -1, 8);
    check_done("depth");

    // z backpressure for 5 cycles on element 5 (mid-row).
    start_block("stall");
    run_block("stall", x_seq, y_ten, z_seq, 0, 5, -1, 8);
    check_done("stall");

    // Reset after 3 of 8 elements, then a fresh block.
    start_block("abort");
    run_block("abort", x_seq, y_ten, z_seq, 0, 99, -1, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_outputs("abort_rst");
    start_block("after_rst");
    run_block("after_rst", x_seq, y_ten, z_seq, 0, 99, -1, 8);
    check_done("after_rst");

    // init pulsed while running is ignored.
    start_block("init_mid");
    run_block("init_mid", x_seq, y_ten, z_seq, 0, 99, 3, 8);
    check_done("init_mid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
